// File: rtl/spi_slave_rx_shifter.sv
`default_nettype none
// spi_slave_rx_shifter: SPI slave receive shifter, single/quad lanes, programmable word length.
// Revision 1.0

module spi_slave_rx_shifter #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 8,
   parameter int RST_TRGT   = 7
) (
   input  logic                  sclk,
   input  logic                  cs,
   input  logic                  sdi0,
   input  logic                  sdi1,
   input  logic                  sdi2,
   input  logic                  sdi3,
   input  logic                  en_quad_in,
   input  logic [CNT_WIDTH-1:0]  counter_in,
   input  logic                  counter_in_upd,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  data_ready
);

   localparam logic [CNT_WIDTH-1:0] c_rst_trgt = CNT_WIDTH'(RST_TRGT);

   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [CNT_WIDTH-1:0]  counter_q, counter_d;
   logic [CNT_WIDTH-1:0]  trgt_q, trgt_d;
   logic                  ready_q, ready_d;
   logic [DATA_WIDTH-1:0] shift_n;

   always_comb begin
      shift_n   = en_quad_in ? {shift_q[DATA_WIDTH-5:0], sdi3, sdi2, sdi1, sdi0}
                             : {shift_q[DATA_WIDTH-2:0], sdi0};
      shift_d   = shift_n;
      data_d    = data_q;
      ready_d   = 1'b0;
      counter_d = counter_q + CNT_WIDTH'(1);
      trgt_d    = counter_in_upd ? counter_in : trgt_q;
      // The completion compare always uses the target in force before this edge's load.
      if (counter_q == trgt_q) begin
         data_d    = shift_n;
         ready_d   = 1'b1;
         shift_d   = '0;
         counter_d = '0;
      end
   end

   always_ff @(posedge sclk or posedge cs) begin
      if (cs) begin
         shift_q   <= '0;
         data_q    <= '0;
         counter_q <= '0;
         trgt_q    <= c_rst_trgt;
         ready_q   <= 1'b0;
      end else begin
         shift_q   <= shift_d;
         data_q    <= data_d;
         counter_q <= counter_d;
         trgt_q    <= trgt_d;
         ready_q   <= ready_d;
      end
   end

   // A target below the running count forces a full counter wrap before the next match.
   always_ff @(posedge sclk) begin
      if (!cs && counter_in_upd)
         assert (counter_in >= counter_d);
   end

   assign data       = data_q;
   assign data_ready = ready_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_rx_shifter.sv
`default_nettype none
// tb_spi_slave_rx_shifter: directed and randomized checks against a word-level receive model.
// Revision 1.0

module tb_spi_slave_rx_shifter;

   logic        sclk;
   logic        cs;
   logic        sdi0, sdi1, sdi2, sdi3;
   logic        en_quad_in;
   logic [7:0]  counter_in;
   logic        counter_in_upd;
   logic [31:0] data;
   logic        data_ready;

   int n_total;
   int n_bad;

   // Reference model: bits collected per word, word length = target + 1 edges.
   int          m_trgt;
   int          m_edges;
   bit          m_bits[$];
   logic [31:0] m_data;
   logic        m_rdy;

   spi_slave_rx_shifter #(
      .DATA_WIDTH(32),
      .CNT_WIDTH (8),
      .RST_TRGT  (7)
   ) dut (
      .sclk          (sclk),
      .cs            (cs),
      .sdi0          (sdi0),
      .sdi1          (sdi1),
      .sdi2          (sdi2),
      .sdi3          (sdi3),
      .en_quad_in    (en_quad_in),
      .counter_in    (counter_in),
      .counter_in_upd(counter_in_upd),
      .data          (data),
      .data_ready    (data_ready)
   );

   initial sclk = 1'b0;
   always #5 sclk = ~sclk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_trgt  = 7;
      m_edges = 0;
      m_bits.delete();
      m_data  = '0;
      m_rdy   = 1'b0;
   endfunction

   function automatic void model_edge(input bit quad, input logic [3:0] nib,
                                      input bit upd, input logic [7:0] cin);
      int n;
      logic [31:0] w;
      if (quad) begin
         m_bits.push_back(nib[3]);
         m_bits.push_back(nib[2]);
         m_bits.push_back(nib[1]);
         m_bits.push_back(nib[0]);
      end else begin
         m_bits.push_back(nib[0]);
      end
      m_edges++;
      if (m_edges == m_trgt + 1) begin
         w = '0;
         n = m_bits.size();
         for (int i = 0; i < 32 && i < n; i++)
            w[i] = m_bits[n-1-i];
         m_data  = w;
         m_rdy   = 1'b1;
         m_edges = 0;
         m_bits.delete();
      end else begin
         m_rdy = 1'b0;
      end
      if (upd) m_trgt = int'(cin);
   endfunction

   // Called just after a falling edge; returns just after the next falling edge.
   task automatic step(input bit quad, input logic [3:0] nib, input bit upd, input logic [7:0] cin);
      en_quad_in     = quad;
      sdi0           = nib[0];
      sdi1           = nib[1];
      sdi2           = nib[2];
      sdi3           = nib[3];
      counter_in_upd = upd;
      counter_in     = cin;
      @(posedge sclk);
      model_edge(quad, nib, upd, cin);
      @(negedge sclk);
      counter_in_upd = 1'b0;
      check_val("data_ready", {31'b0, data_ready}, {31'b0, m_rdy});
      check_val("data", data, m_data);
   endtask

   task automatic cs_pulse();
      @(negedge sclk);
      cs = 1'b1;
      #1;
      model_reset();
      check_val("cs_data", data, 32'h0);
      check_val("cs_rdy", {31'b0, data_ready}, 32'h0);
      @(negedge sclk);
      cs = 1'b0;
   endtask

   task automatic send_single_word(input logic [31:0] w, input int nbits);
      for (int i = nbits - 1; i >= 0; i--)
         step(1'b0, {3'b0, w[i]}, 1'b0, 8'd0);
   endtask

   initial begin : main
      logic [7:0]  b1;
      logic [31:0] words [2];
      logic [3:0]  nibs  [8];
      logic [3:0]  n3    [3];
      bit          quad;
      bit          upd;
      logic [7:0]  cin;
      n_total        = 0;
      n_bad          = 0;
      cs             = 1'b1;
      sdi0           = 1'b0;
      sdi1           = 1'b0;
      sdi2           = 1'b0;
      sdi3           = 1'b0;
      en_quad_in     = 1'b0;
      counter_in     = 8'd0;
      counter_in_upd = 1'b0;
      model_reset();

      @(negedge sclk);
      @(negedge sclk);
      check_val("reset_data", data, 32'h0);
      check_val("reset_rdy", {31'b0, data_ready}, 32'h0);
      cs = 1'b0;

      // Command byte in single mode.
      b1 = 8'hB2;
      send_single_word({24'h0, b1}, 8);
      check_val("t1_data", data, 32'h000000B2);
      check_val("t1_rdy", {31'b0, data_ready}, 32'h1);
      step(1'b0, 4'h0, 1'b0, 8'd0);
      check_val("t1_rdy_drop", {31'b0, data_ready}, 32'h0);
      cs_pulse();
      send_single_word({24'h0, b1}, 8);

      // Quad word of eight nibbles.
      nibs = '{4'hD, 4'hE, 4'hA, 4'hD, 4'hB, 4'hE, 4'hE, 4'hF};
      for (int i = 0; i < 8; i++)
         step(1'b1, nibs[i], i == 0, 8'd7);
      check_val("t2_data", data, 32'hDEADBEEF);
      check_val("t2_rdy", {31'b0, data_ready}, 32'h1);

      // Two 32-bit single-mode words; target loaded on the first edge.
      words = '{32'hCAFEF00D, 32'h12345678};
      for (int k = 0; k < 2; k++) begin
         for (int i = 31; i >= 0; i--)
            step(1'b0, {3'b0, words[k][i]}, (k == 0) && (i == 31), 8'd31);
         check_val("t3_data", data, words[k]);
         check_val("t3_rdy", {31'b0, data_ready}, 32'h1);
      end

      // Abort mid-byte, then a clean byte at the reset target.
      send_single_word(32'h15, 5);
      cs_pulse();
      send_single_word(32'h5A, 8);
      check_val("t4_data", data, 32'h0000005A);

      // Target change on a completion edge takes effect for the following word.
      for (int i = 7; i >= 0; i--)
         step(1'b0, {3'b0, b1[i]}, i == 0, 8'd3);
      check_val("t5_byte", data, 32'h000000B2);
      send_single_word(32'h9, 4);
      check_val("t5_nib", data, 32'h00000009);
      check_val("t5_rdy", {31'b0, data_ready}, 32'h1);

      // Target 0 in quad mode: every edge completes.
      send_single_word(32'h0, 3);
      step(1'b0, 4'h1, 1'b1, 8'd0);
      n3 = '{4'h3, 4'h9, 4'hC};
      for (int i = 0; i < 3; i++) begin
         step(1'b1, n3[i], 1'b0, 8'd0);
         check_val("t6_data", data, {28'h0, n3[i]});
         check_val("t6_rdy", {31'b0, data_ready}, 32'h1);
      end

      // Randomized traffic: mode and target change only at word boundaries.
      quad = 1'b0;
      for (int e = 0; e < 1500; e++) begin
         if ($urandom_range(0, 99) == 0) begin
            cs_pulse();
         end else begin
            if (m_edges == 0) quad = bit'($urandom_range(0, 1));
            upd = (m_edges == m_trgt) && ($urandom_range(0, 2) == 0);
            cin = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 40))
                                               : 8'($urandom_range(0, 9));
            step(quad, 4'($urandom_range(0, 15)), upd, cin);
         end
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
